// File: rtl/ecg_pkg.sv
// ecg_pkg: shared state type, sample width and buffer defaults for the ECG RAM scheduler
package ecg_pkg;
  localparam int SAMPLE_W = 12;
  localparam int PTR_W = 11;
  localparam logic [11:0] DEF_BASE_ADDR = 12'h801;
  localparam int DEF_BUF_LEN = 640;
  typedef enum logic [1:0] {CLEAR, RUN, FROZEN} state_t;
endpackage

// File: rtl/ecg_ram_scheduler_if.sv
// ecg_ram_scheduler_if: sample-write, column-read and RAM port bundle of the ECG RAM scheduler
interface ecg_ram_scheduler_if;
  import ecg_pkg::*;
  logic wr_valid, wr_ready;
  logic [SAMPLE_W-1:0] wr_sample;
  logic rd_req, rd_valid;
  logic [9:0] rd_col;
  logic [SAMPLE_W-1:0] rd_sample;
  logic [11:0] ram_addr;
  logic ram_we;
  logic [31:0] ram_wdata, ram_rdata;
  modport master (output wr_valid, wr_sample, rd_req, rd_col, ram_rdata,
                  input wr_ready, rd_valid, rd_sample, ram_addr, ram_we, ram_wdata);
  modport slave (input wr_valid, wr_sample, rd_req, rd_col, ram_rdata,
                 output wr_ready, rd_valid, rd_sample, ram_addr, ram_we, ram_wdata);
endinterface

// File: rtl/ecg_ptr_wrap.sv
// ecg_ptr_wrap: (a + b) mod BUF_LEN for operands below BUF_LEN; b = 1 gives increment-with-wrap
module ecg_ptr_wrap import ecg_pkg::*; #(
  parameter int BUF_LEN = DEF_BUF_LEN
) (
  input  logic [PTR_W-1:0] a,
  input  logic [PTR_W-1:0] b,
  output logic [PTR_W-1:0] y
);
  logic [11:0] sum;
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    y = PTR_W'(sum >= 12'(BUF_LEN) ? sum - 12'(BUF_LEN) : sum);
  end
endmodule

// File: rtl/ecg_ram_scheduler.sv
// ecg_ram_scheduler: shares one single-port RAM between ADC sample writes and display column reads.
// Define ECG_CLEAR_EN to compile in the post-reset zero-fill sweep of the sample buffer.
module ecg_ram_scheduler import ecg_pkg::*; #(
  parameter logic [11:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int BUF_LEN = DEF_BUF_LEN
) (
  input  logic clock,
  input  logic reset,
  input  logic frame_end,
  input  logic freeze,
  output logic busy_clear,
  ecg_ram_scheduler_if.slave bus
);
  state_t state_q, state_d;
  logic skid_full_q, skid_full_d;
  logic [SAMPLE_W-1:0] skid_q, skid_d, rd_sample_q, rd_sample_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, disp_ptr_q, disp_ptr_d, wr_inc, rd_off, clr_ptr_q;
  logic [11:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic ram_we_q, ram_we_d, rv1_q, rv1_d, oob1_q, oob1_d, rv2_q, oob2_q, rd_valid_q;
  logic wr_acc, rd_hit, drain, clr_go, clr_last, unused_rdata;

  ecg_ptr_wrap #(.BUF_LEN(BUF_LEN)) u_wr (.a(wr_ptr_q), .b(PTR_W'(1)), .y(wr_inc));
  ecg_ptr_wrap #(.BUF_LEN(BUF_LEN)) u_rd (.a(disp_ptr_q), .b({1'b0, bus.rd_col}), .y(rd_off));

`ifdef ECG_CLEAR_EN
  localparam state_t RST_STATE = CLEAR;
  logic [PTR_W-1:0] clr_ptr_d, clr_inc;
  ecg_ptr_wrap #(.BUF_LEN(BUF_LEN)) u_clr (.a(clr_ptr_q), .b(PTR_W'(1)), .y(clr_inc));
  always_comb begin
    clr_go = state_q == CLEAR && !bus.rd_req;
    clr_last = clr_go && clr_ptr_q == PTR_W'(BUF_LEN - 1);
    clr_ptr_d = clr_go ? clr_inc : clr_ptr_q;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) clr_ptr_q <= '0;
    else clr_ptr_q <= clr_ptr_d;
  assign busy_clear = state_q == CLEAR;
`else
  localparam state_t RST_STATE = RUN;
  assign clr_go = 1'b0;
  assign clr_last = 1'b0;
  assign clr_ptr_q = '0;
  assign busy_clear = 1'b0;
`endif

  // reads own the port whenever requested; the skid and the clear sweep only use idle slots
  always_comb begin
    wr_acc = bus.wr_valid && !skid_full_q && state_q != CLEAR;
    rd_hit = bus.rd_req && {2'b0, bus.rd_col} < 12'(BUF_LEN);
    drain = skid_full_q && !bus.rd_req;
    skid_full_d = wr_acc || (skid_full_q && !drain);
    skid_d = wr_acc ? bus.wr_sample : skid_q;
    wr_ptr_d = drain ? wr_inc : wr_ptr_q;
    disp_ptr_d = frame_end && !freeze ? wr_ptr_d : disp_ptr_q;
    state_d = state_q == CLEAR ? (clr_last ? RUN : CLEAR) : frame_end ? (freeze ? FROZEN : RUN) : state_q;
    ram_we_d = drain || clr_go;
    ram_addr_d = rd_hit ? BASE_ADDR + 12'(rd_off) : drain ? BASE_ADDR + 12'(wr_ptr_q) :
                 clr_go ? BASE_ADDR + 12'(clr_ptr_q) : BASE_ADDR;
    ram_wdata_d = drain ? {20'd0, skid_q} : 32'd0;
    rv1_d = bus.rd_req;
    oob1_d = bus.rd_req && !rd_hit;
    rd_sample_d = rv2_q ? (oob2_q ? '0 : bus.ram_rdata[SAMPLE_W-1:0]) : rd_sample_q;
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= RST_STATE;
      skid_full_q <= 1'b0;
      skid_q <= '0;
      wr_ptr_q <= '0;
      disp_ptr_q <= '0;
      ram_addr_q <= BASE_ADDR;
      ram_we_q <= 1'b0;
      ram_wdata_q <= '0;
      rv1_q <= 1'b0;
      oob1_q <= 1'b0;
      rv2_q <= 1'b0;
      oob2_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_sample_q <= '0;
    end else begin
      state_q <= state_d;
      skid_full_q <= skid_full_d;
      skid_q <= skid_d;
      wr_ptr_q <= wr_ptr_d;
      disp_ptr_q <= disp_ptr_d;
      ram_addr_q <= ram_addr_d;
      ram_we_q <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      rv1_q <= rv1_d;
      oob1_q <= oob1_d;
      rv2_q <= rv1_q;
      oob2_q <= oob1_q;
      rd_valid_q <= rv2_q;
      rd_sample_q <= rd_sample_d;
    end

  assign bus.wr_ready = !skid_full_q && state_q != CLEAR;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_sample = rd_sample_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_we = ram_we_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign unused_rdata = ^bus.ram_rdata[31:SAMPLE_W];
endmodule
